cv32e41s_sleep_ctrl: RTL and testbench

Sleep controller that generates the enable for the core clock gate. It runs on the ungated clock and watches a sleep request, pipeline busy flags and wake sources. It drops `clock_en_o` only after the pipeline has been idle for a programmable number of cycles. It restores the clock on an interrupt or debug wake-up and acknowledges the wake once a settle period has elapsed.

---
 rtl/cv32e41s_sleep_ctrl_if.sv | 22 ++
 rtl/cv32e41s_sleep_ctrl.sv | 99 +++++++++
 tb/tb_cv32e41s_sleep_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/cv32e41s_sleep_ctrl_if.sv
// rtl/cv32e41s_sleep_ctrl_if.sv - core-side sleep/wake signal bundle for the sleep controller
interface cv32e41s_sleep_ctrl_if;
  logic sleep_req_i;
  logic fetch_busy_i;
  logic lsu_busy_i;
  logic wb_busy_i;
  logic irq_wu_i;
  logic debug_req_i;
  logic clock_en_o;
  logic core_sleep_o;
  logic wake_ack_o;

  modport master (
    output sleep_req_i, fetch_busy_i, lsu_busy_i, wb_busy_i, irq_wu_i, debug_req_i,
    input  clock_en_o, core_sleep_o, wake_ack_o
  );

  modport slave (
    input  sleep_req_i, fetch_busy_i, lsu_busy_i, wb_busy_i, irq_wu_i, debug_req_i,
    output clock_en_o, core_sleep_o, wake_ack_o
  );
endinterface

// File: rtl/cv32e41s_sleep_ctrl.sv
// rtl/cv32e41s_sleep_ctrl.sv - clock-gate enable controller: drain, sleep, wake with settle period
module cv32e41s_sleep_ctrl #(
  parameter int unsigned IDLE_CYCLES = 4,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic                        clk_ungated_i,
  input  logic                        rst_n,
  cv32e41s_sleep_ctrl_if.slave        bus
);

  if (IDLE_CYCLES < 1 || IDLE_CYCLES > 255) begin : gen_bad_idle
    $error("IDLE_CYCLES out of range 1..255");
  end
  if (WAKE_CYCLES < 1 || WAKE_CYCLES > 255) begin : gen_bad_wake
    $error("WAKE_CYCLES out of range 1..255");
  end

  localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYCLES - 1);
  localparam logic [7:0] WAKE_LAST = 8'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SLEEP = 2'd2,
    WAKE  = 2'd3
  } state_e;

  state_e     state_q;
  logic [7:0] cnt_q;
  logic       clock_en_q;
  logic       core_sleep_q;
  logic       wake_ack_q;

  logic wake_evt;
  logic idle;

  assign wake_evt = bus.irq_wu_i | bus.debug_req_i;
  assign idle     = ~bus.fetch_busy_i & ~bus.lsu_busy_i & ~bus.wb_busy_i;

  // Outputs are updated alongside the state so the gate enable is a clean flop output.
  always_ff @(posedge clk_ungated_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      cnt_q        <= 8'd0;
      clock_en_q   <= 1'b1;
      core_sleep_q <= 1'b0;
      wake_ack_q   <= 1'b0;
    end else begin
      wake_ack_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (bus.sleep_req_i && !wake_evt) begin
            state_q <= DRAIN;
            cnt_q   <= 8'd0;
          end
        end
        DRAIN: begin
          if (wake_evt || !bus.sleep_req_i) begin
            state_q <= RUN;
          end else if (!idle) begin
            cnt_q <= 8'd0;
          end else if (cnt_q == IDLE_LAST) begin
            state_q      <= SLEEP;
            clock_en_q   <= 1'b0;
            core_sleep_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        SLEEP: begin
          if (wake_evt) begin
            state_q      <= WAKE;
            cnt_q        <= 8'd0;
            clock_en_q   <= 1'b1;
            core_sleep_q <= 1'b0;
          end
        end
        WAKE: begin
          if (cnt_q == WAKE_LAST) begin
            state_q    <= RUN;
            wake_ack_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          state_q      <= RUN;
          clock_en_q   <= 1'b1;
          core_sleep_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.clock_en_o   = clock_en_q;
  assign bus.core_sleep_o = core_sleep_q;
  assign bus.wake_ack_o   = wake_ack_q;

endmodule

// File: tb/tb_cv32e41s_sleep_ctrl.sv
// tb/tb_cv32e41s_sleep_ctrl.sv - directed scoreboard bench for the sleep controller
module tb_cv32e41s_sleep_ctrl;

  logic clk;
  logic rst_n;

  cv32e41s_sleep_ctrl_if ifa ();
  cv32e41s_sleep_ctrl_if ifb ();

  cv32e41s_sleep_ctrl #(.IDLE_CYCLES(4), .WAKE_CYCLES(2)) u_dut_a (
    .clk_ungated_i (clk),
    .rst_n         (rst_n),
    .bus           (ifa.slave)
  );

  cv32e41s_sleep_ctrl #(.IDLE_CYCLES(1), .WAKE_CYCLES(1)) u_dut_b (
    .clk_ungated_i (clk),
    .rst_n         (rst_n),
    .bus           (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit    sel;
    logic  en;
    logic  ack;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Expected outputs after the next edge are queued, then popped once the edge has happened.
  task automatic step(input bit sel, input logic en, input logic ack, input string tag);
    exp_t e;
    logic o_en, o_sl, o_ack;
    e.sel = sel; e.en = en; e.ack = ack; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e    = sb.pop_front();
    o_en  = e.sel ? ifb.clock_en_o   : ifa.clock_en_o;
    o_sl  = e.sel ? ifb.core_sleep_o : ifa.core_sleep_o;
    o_ack = e.sel ? ifb.wake_ack_o   : ifa.wake_ack_o;
    chk({e.tag, "/clock_en"},   o_en,  e.en);
    chk({e.tag, "/core_sleep"}, o_sl,  ~e.en);
    chk({e.tag, "/wake_ack"},   o_ack, e.ack);
  endtask

  initial begin
    rst_n = 1'b0;
    ifa.sleep_req_i = 0; ifa.fetch_busy_i = 0; ifa.lsu_busy_i = 0;
    ifa.wb_busy_i = 0; ifa.irq_wu_i = 0; ifa.debug_req_i = 0;
    ifb.sleep_req_i = 0; ifb.fetch_busy_i = 0; ifb.lsu_busy_i = 0;
    ifb.wb_busy_i = 0; ifb.irq_wu_i = 0; ifb.debug_req_i = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset/clock_en",   ifa.clock_en_o,   1'b1);
    chk("reset/core_sleep", ifa.core_sleep_o, 1'b0);
    chk("reset/wake_ack",   ifa.wake_ack_o,   1'b0);
    chk("reset_b/clock_en", ifb.clock_en_o,   1'b1);
    rst_n = 1'b1;

    // Basic entry and irq wake
    ifa.sleep_req_i = 1;
    step(0, 1, 0, "t1_e0");
    for (int i = 0; i < 3; i++) step(0, 1, 0, "t1_drain");
    step(0, 0, 0, "t1_gate");
    step(0, 0, 0, "t1_hold");
    ifa.irq_wu_i = 1;
    step(0, 1, 0, "t1_wake_w");
    ifa.irq_wu_i = 0;
    step(0, 1, 0, "t1_wake_w1");
    ifa.sleep_req_i = 0;
    step(0, 1, 1, "t1_ack");
    step(0, 1, 0, "t1_ack_clr");

    // LSU busy for the first DRAIN cycles, then a wb blip at the final compare
    ifa.sleep_req_i = 1; ifa.lsu_busy_i = 1;
    step(0, 1, 0, "t2_e0");
    for (int i = 0; i < 3; i++) step(0, 1, 0, "t2_busy");
    ifa.lsu_busy_i = 0;
    for (int i = 0; i < 3; i++) step(0, 1, 0, "t2_count");
    ifa.wb_busy_i = 1;
    step(0, 1, 0, "t2_blip");
    ifa.wb_busy_i = 0;
    for (int i = 0; i < 3; i++) step(0, 1, 0, "t2_recount");
    step(0, 0, 0, "t2_gate");
    ifa.sleep_req_i = 0; ifa.fetch_busy_i = 1;
    step(0, 0, 0, "t2_sleep_hold");
    ifa.fetch_busy_i = 0; ifa.debug_req_i = 1;
    step(0, 1, 0, "t2_dbg_wake");
    ifa.debug_req_i = 0;
    step(0, 1, 0, "t2_wake1");
    step(0, 1, 1, "t2_ack");
    step(0, 1, 0, "t2_ack_clr");

    // Debug wins over the final idle compare; sleep+irq in RUN stays in RUN
    ifa.sleep_req_i = 1;
    step(0, 1, 0, "t3_e0");
    for (int i = 0; i < 3; i++) step(0, 1, 0, "t3_drain");
    ifa.debug_req_i = 1;
    step(0, 1, 0, "t3_abort");
    step(0, 1, 0, "t3_run_dbg");
    ifa.debug_req_i = 0; ifa.irq_wu_i = 1;
    step(0, 1, 0, "t3_run_irq");
    step(0, 1, 0, "t3_run_irq2");
    ifa.irq_wu_i = 0;
    step(0, 1, 0, "t3_e0b");
    for (int i = 0; i < 3; i++) step(0, 1, 0, "t3_drainb");
    step(0, 0, 0, "t3_gate");
    ifa.irq_wu_i = 1;
    step(0, 1, 0, "t3_wake");
    ifa.irq_wu_i = 0; ifa.sleep_req_i = 0;
    step(0, 1, 0, "t3_wake1");
    step(0, 1, 1, "t3_ack");
    step(0, 1, 0, "t3_ack_clr");

    // Sleep request withdrawn mid-DRAIN restarts from RUN
    ifa.sleep_req_i = 1;
    step(0, 1, 0, "t4_e0");
    step(0, 1, 0, "t4_cnt1");
    ifa.sleep_req_i = 0;
    step(0, 1, 0, "t4_abort");
    ifa.sleep_req_i = 1;
    step(0, 1, 0, "t4_e0b");
    for (int i = 0; i < 3; i++) step(0, 1, 0, "t4_drain");
    step(0, 0, 0, "t4_gate");

    // Async reset while sleeping
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst/clock_en",   ifa.clock_en_o,   1'b1);
    chk("async_rst/core_sleep", ifa.core_sleep_o, 1'b0);
    chk("async_rst/wake_ack",   ifa.wake_ack_o,   1'b0);
    ifa.sleep_req_i = 0;
    #1;
    rst_n = 1'b1;
    step(0, 1, 0, "t5_post_rst");

    // IDLE_CYCLES=1, WAKE_CYCLES=1 back-to-back cycles
    ifb.sleep_req_i = 1;
    step(1, 1, 0, "b_e0");
    step(1, 0, 0, "b_gate");
    for (int r = 0; r < 2; r++) begin
      ifb.irq_wu_i = 1;
      step(1, 1, 0, "b_wake");
      ifb.irq_wu_i = 0;
      step(1, 1, 1, "b_ack");
      step(1, 1, 0, "b_redrain");
      step(1, 0, 0, "b_regate");
    end
    ifb.irq_wu_i = 1;
    step(1, 1, 0, "b_wake_last");
    ifb.irq_wu_i = 0; ifb.sleep_req_i = 0;
    step(1, 1, 1, "b_ack_last");
    step(1, 1, 0, "b_run");
    step(1, 1, 0, "b_run2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
